// File: rtl/cp_sync_tx.sv
// Synchronous-to-micropipeline transmitter: buffers valid/ready words in a small FIFO
// and issues each one as a two-phase bundled-data transfer (req toggle, ack toggle).
module cp_sync_tx #(
    parameter int WIDTH     = 3,
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     req_out,
    output logic [WIDTH-1:0]         data_out,
    input  logic                     ack_in,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int SCW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYC - 1);
    localparam logic [CW-1:0]  FULL       = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic [SCW-1:0]     setup_cnt_reg;
    logic               ack_s1;
    logic               ack_s2;
    logic               ack_prev;
    logic               req_reg;
    logic               err_reg;
    logic [WIDTH-1:0]   data_reg;
    logic               push;
    logic               pop;

    assign in_ready = (count_reg != FULL);
    assign push     = in_valid && in_ready;
    // The only pop point is the IDLE->SETUP load, so at most one word is in flight.
    assign pop      = (state_reg == IDLE) && (count_reg != '0);

    assign req_out  = req_reg;
    assign data_out = data_reg;
    assign count    = count_reg;
    assign err      = err_reg;
    assign busy     = (state_reg != IDLE) || (count_reg != '0);

    // Storage has no reset: flushing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ack_in comes from the self-timed side, so it is resynchronised before use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_s1   <= 1'b0;
            ack_s2   <= 1'b0;
            ack_prev <= 1'b0;
        end else begin
            ack_s1   <= ack_in;
            ack_s2   <= ack_s1;
            ack_prev <= ack_s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            req_reg       <= 1'b0;
            data_reg      <= '0;
            setup_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            // An ack edge outside WAIT_ACK is spurious or duplicated; flag it, never act on it.
            if ((ack_s2 != ack_prev) && (state_reg != WAIT_ACK)) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (count_reg != '0) begin
                        data_reg      <= mem[rd_ptr_reg];
                        setup_cnt_reg <= '0;
                        state_reg     <= SETUP;
                    end
                end
                SETUP: begin
                    setup_cnt_reg <= setup_cnt_reg + SCW'(1);
                    if (setup_cnt_reg == SETUP_LAST) begin
                        req_reg   <= ~req_reg;
                        state_reg <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_s2 == req_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
